// File: rtl/paper_sequencer.sv
// Fetch/decode/execute sequencer for the 2-bit-opcode paper processor.
// Fetches over req/ack, strobes inc/dec into the datapath, resolves JNO from reg_zero.
module paper_sequencer #(
    parameter int PC_W      = 4,
    parameter int REG_SEL_W = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 force_halt,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [2+REG_SEL_W+PC_W-1:0] imem_data,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 inc_en,
    output logic                 dec_en,
    input  logic                 reg_zero,
    output logic                 busy,
    output logic                 halted,
    output logic [PC_W-1:0]      pc,
    output logic [CNT_W-1:0]     instr_count
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // FETCH  | imem_req high, waiting for imem_ack
    // DECODE | latch force_halt and register select
    // EXEC   | strobe datapath, update pc, retire instruction
    // HALT   | HLT executed, waiting for start
    localparam int IW = 2 + REG_SEL_W + PC_W;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_JNO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                 state, state_nx;
    logic [PC_W-1:0]        pc_nx;
    logic [IW-1:0]          ir, ir_nx;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   force_halt_q, force_halt_nx;
    logic [REG_SEL_W-1:0]   reg_sel_nx;

    logic [1:0]             ir_op;
    logic [REG_SEL_W-1:0]   ir_reg;
    logic [PC_W-1:0]        ir_tgt;
    logic [1:0]             eff_op;

    assign ir_op  = ir[IW-1 -: 2];
    assign ir_reg = ir[PC_W +: REG_SEL_W];
    assign ir_tgt = ir[PC_W-1:0];
    assign eff_op = ir_op | {2{force_halt_q}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ir           <= '0;
            instr_count  <= '0;
            force_halt_q <= 1'b0;
            reg_sel      <= '0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            ir           <= ir_nx;
            instr_count  <= cnt_nx;
            force_halt_q <= force_halt_nx;
            reg_sel      <= reg_sel_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        ir_nx         = ir;
        cnt_nx        = instr_count;
        force_halt_nx = force_halt_q;
        reg_sel_nx    = reg_sel;
        imem_req      = 1'b0;
        inc_en        = 1'b0;
        dec_en        = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                    cnt_nx   = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nx    = imem_data;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                force_halt_nx = force_halt;
                reg_sel_nx    = ir_reg;
                state_nx      = S_EXEC;
            end
            S_EXEC: begin
                // saturating retire counter; HLT retires too
                cnt_nx   = (&instr_count) ? instr_count : instr_count + 1'b1;
                state_nx = S_FETCH;
                case (eff_op)
                    OP_INC: begin
                        inc_en = 1'b1;
                        pc_nx  = pc + 1'b1;
                    end
                    OP_DEC: begin
                        dec_en = 1'b1;
                        pc_nx  = pc + 1'b1;
                    end
                    OP_JNO: pc_nx = reg_zero ? pc + 1'b1 : ir_tgt;
                    default: state_nx = S_HALT;
                endcase
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_paper_sequencer.sv
// Directed bench for paper_sequencer: memory with programmable ack delay, a
// four-register datapath model, and a second PC_W=2 instance for pc wrap.
module tb_paper_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       force_halt = 1'b0;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [1:0] reg_sel;
    logic       inc_en, dec_en, reg_zero, busy, halted;
    logic [3:0] pc;
    logic [7:0] instr_count;

    logic       start2 = 1'b0;
    logic       req2, inc2, dec2, busy2, halted2;
    logic [1:0] addr2, sel2, pc2;
    logic [7:0] cnt2;

    logic [7:0] mem [16];
    logic [7:0] regs [4];
    logic [7:0] dp_init [4];
    logic       dp_load = 1'b0;
    int         ack_delay = 0;
    int         wait_cnt = 0;
    int         inc_total = 0;
    int         dec_total = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paper_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .force_halt(force_halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .reg_sel(reg_sel), .inc_en(inc_en), .dec_en(dec_en), .reg_zero(reg_zero),
        .busy(busy), .halted(halted), .pc(pc), .instr_count(instr_count)
    );

    // Always-acking memory full of INC r0, so the 2-bit pc must wrap
    paper_sequencer #(.PC_W(2), .REG_SEL_W(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .force_halt(1'b0),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_data(6'b00_00_00),
        .reg_sel(sel2), .inc_en(inc2), .dec_en(dec2), .reg_zero(1'b0),
        .busy(busy2), .halted(halted2), .pc(pc2), .instr_count(cnt2)
    );

    assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
    assign imem_data = imem_ack ? mem[imem_addr] : 8'b01_11_1111;
    assign reg_zero  = (regs[reg_sel] == 8'd0);

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
        if (dp_load) begin
            for (int i = 0; i < 4; i++) regs[i] <= dp_init[i];
        end else begin
            if (inc_en) regs[reg_sel] <= regs[reg_sel] + 8'd1;
            if (dec_en) regs[reg_sel] <= regs[reg_sel] - 8'd1;
        end
        if (inc_en) inc_total <= inc_total + 1;
        if (dec_en) dec_total <= dec_total + 1;
    end

    function automatic logic [7:0] enc(input logic [1:0] op, input logic [1:0] r, input logic [3:0] t);
        return {op, r, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_regs(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
        dp_init[0] = r0; dp_init[1] = r1; dp_init[2] = r2; dp_init[3] = r3;
        dp_load = 1'b1;
        @(negedge clk);
        dp_load = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;
    int inc0, dec0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hC0;
        for (int i = 0; i < 4; i++) dp_init[i] = 8'd0;

        // Reset asserted between clock edges, start held high meanwhile
        #1 rst = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_strobes", {inc_en, dec_en, reg_sel}, 0);
        cyc(2);
        chk("rst_start_ignored", {busy, imem_req}, 0);
        start = 1'b0;
        rst = 1'b0;
        load_regs(8'd0, 8'd0, 8'd0, 8'd0);

        // INC r1; DEC r1; JNO r1->0 (falls through); HLT
        mem[0] = enc(2'b00, 2'd1, 4'd0);
        mem[1] = enc(2'b01, 2'd1, 4'd0);
        mem[2] = enc(2'b10, 2'd1, 4'd0);
        mem[3] = enc(2'b11, 2'd0, 4'd0);
        inc0 = inc_total; dec0 = dec_total;
        run_start();
        chk("p1_fetch_req", imem_req, 1);
        wait_halt(40, n);
        chk("p1_latency", n, 12);
        chk("p1_halted", halted, 1);
        chk("p1_pc", pc, 3);
        chk("p1_cnt", instr_count, 4);
        chk("p1_inc", inc_total - inc0, 1);
        chk("p1_dec", dec_total - dec0, 1);
        chk("p1_r1", regs[1], 0);

        // DEC r2; JNO r2->0; HLT with r2=3
        load_regs(8'd0, 8'd0, 8'd3, 8'd0);
        mem[0] = enc(2'b01, 2'd2, 4'd0);
        mem[1] = enc(2'b10, 2'd2, 4'd0);
        mem[2] = enc(2'b11, 2'd0, 4'd0);
        inc0 = inc_total; dec0 = dec_total;
        run_start();
        chk("p2_restart_pc", pc, 0);
        chk("p2_restart_cnt", instr_count, 0);
        wait_halt(60, n);
        chk("p2_latency", n, 21);
        chk("p2_pc", pc, 2);
        chk("p2_cnt", instr_count, 7);
        chk("p2_dec", dec_total - dec0, 3);
        chk("p2_inc", inc_total - inc0, 0);

        // Fetch stalled for 5 cycles on INC r0; HLT
        mem[0] = enc(2'b00, 2'd0, 4'd0);
        mem[1] = enc(2'b11, 2'd0, 4'd0);
        ack_delay = 5;
        inc0 = inc_total;
        run_start();
        for (int i = 0; i < 6; i++) begin
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, 0);
            chk("stall_strobes", {inc_en, dec_en}, 0);
            cyc(1);
        end
        chk("stall_req_drop", imem_req, 0);
        chk("stall_decode_busy", busy, 1);
        wait_halt(40, n);
        chk("stall_inc", inc_total - inc0, 1);
        chk("stall_pc", pc, 1);
        chk("stall_cnt", instr_count, 2);
        ack_delay = 0;

        // force_halt during DECODE of the second INC r0
        mem[0] = enc(2'b00, 2'd0, 4'd0);
        mem[1] = enc(2'b00, 2'd0, 4'd0);
        mem[2] = enc(2'b11, 2'd0, 4'd0);
        inc0 = inc_total;
        run_start();
        cyc(4);
        force_halt = 1'b1;
        cyc(1);
        force_halt = 1'b0;
        chk("fh_no_inc", inc_en, 0);
        chk("fh_exec_pc", pc, 1);
        cyc(1);
        chk("fh_halted", halted, 1);
        chk("fh_pc", pc, 1);
        chk("fh_cnt", instr_count, 2);
        chk("fh_inc_total", inc_total - inc0, 1);
        run_start();
        chk("fh_restart_pc", pc, 0);
        chk("fh_restart_addr", imem_addr, 0);
        chk("fh_restart_busy", busy, 1);
        wait_halt(40, n);
        chk("fh_rerun_cnt", instr_count, 3);

        // PC_W=2 instance: INC at address 3 wraps pc to 0
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc(9);
        chk("wrap_pc3", pc2, 3);
        cyc(3);
        chk("wrap_pc0", pc2, 0);
        chk("wrap_cnt", cnt2, 4);
        chk("wrap_addr", addr2, 0);

        // Reset in the middle of a stalled fetch at pc=1
        mem[0] = enc(2'b00, 2'd0, 4'd0);
        mem[1] = enc(2'b11, 2'd0, 4'd0);
        run_start();
        cyc(3);
        ack_delay = 5;
        cyc(1);
        chk("midrst_pre_req", imem_req, 1);
        chk("midrst_pre_pc", pc, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", instr_count, 0);
        chk("midrst_dut2", {busy2, cnt2}, 0);
        cyc(1);
        rst = 1'b0;
        ack_delay = 0;
        cyc(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
